// File: rtl/mips_pkg.sv
// Shared instruction-set definitions: op kinds, 6-bit control codes, field positions.
// The control decoder consumes the same code constants the loader encodes with.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT, OP_DIV, OP_MULT,
        OP_MFHI, OP_MFLO, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J,
        OP_INVALID = 4'd15
    } op_kind_e;

    typedef enum logic [1:0] { FMT_R, FMT_I, FMT_J } fmt_e;

    typedef enum logic [1:0] { ST_IDLE, ST_LOAD, ST_DONE, ST_ERR } ld_state_e;

    localparam logic [5:0] CODE_AND  = 6'b100100;
    localparam logic [5:0] CODE_OR   = 6'b100101;
    localparam logic [5:0] CODE_NOR  = 6'b100111;
    localparam logic [5:0] CODE_ADD  = 6'b100000;
    localparam logic [5:0] CODE_SUB  = 6'b100010;
    localparam logic [5:0] CODE_SLT  = 6'b101010;
    localparam logic [5:0] CODE_DIV  = 6'b101111;
    localparam logic [5:0] CODE_MULT = 6'b101000;
    localparam logic [5:0] CODE_MFHI = 6'b010000;
    localparam logic [5:0] CODE_MFLO = 6'b010010;
    localparam logic [5:0] CODE_ADDI = 6'b001000;
    localparam logic [5:0] CODE_LW   = 6'b100011;
    localparam logic [5:0] CODE_SW   = 6'b101011;
    localparam logic [5:0] CODE_BEQ  = 6'b000100;
    localparam logic [5:0] CODE_J    = 6'b000010;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_W     = 16;
    localparam int TGT_W     = 26;

    function automatic logic [5:0] op_code(input op_kind_e op);
        case (op)
            OP_AND:  return CODE_AND;
            OP_OR:   return CODE_OR;
            OP_NOR:  return CODE_NOR;
            OP_ADD:  return CODE_ADD;
            OP_SUB:  return CODE_SUB;
            OP_SLT:  return CODE_SLT;
            OP_DIV:  return CODE_DIV;
            OP_MULT: return CODE_MULT;
            OP_MFHI: return CODE_MFHI;
            OP_MFLO: return CODE_MFLO;
            OP_ADDI: return CODE_ADDI;
            OP_LW:   return CODE_LW;
            OP_SW:   return CODE_SW;
            OP_BEQ:  return CODE_BEQ;
            OP_J:    return CODE_J;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic fmt_e op_fmt(input op_kind_e op);
        case (op)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: return FMT_I;
            OP_J:                          return FMT_J;
            default:                       return FMT_R;
        endcase
    endfunction

endpackage

// File: rtl/inst_encoder.sv
// Combinational packer: op kind plus register/immediate fields -> 32-bit word.
// R-format words repeat the control code in the funct field.
module inst_encoder
    import mips_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        invalid
);

    logic [5:0] code;
    fmt_e       fmt;

    always_comb begin
        word    = '0;
        invalid = 1'b0;
        code    = op_code(op_kind_e'(op));
        fmt     = op_fmt(op_kind_e'(op));
        if (op_kind_e'(op) == OP_INVALID) begin
            invalid = 1'b1;
        end else begin
            word[OP_LSB +: 6] = code;
            case (fmt)
                FMT_R: begin
                    word[RS_LSB +: 5]    = rs;
                    word[RT_LSB +: 5]    = rt;
                    word[RD_LSB +: 5]    = rd;
                    word[SHAMT_LSB +: 5] = 5'd0;
                    word[FUNCT_LSB +: 6] = code;
                end
                FMT_I: begin
                    word[RS_LSB +: 5] = rs;
                    word[RT_LSB +: 5] = rt;
                    word[IMM_W-1:0]   = imm[IMM_W-1:0];
                end
                default: word[TGT_W-1:0] = imm;
            endcase
        end
    end

endmodule

// File: rtl/inst_program_loader.sv
// Stream-to-memory program loader: encodes accepted descriptions and writes
// them to consecutive instruction-memory words starting at a latched base.
module inst_program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   ww_q, ww_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [31:0] enc_word;
    logic        enc_invalid;
    logic        accept;

    inst_encoder u_enc (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .invalid (enc_invalid)
    );

    assign busy     = (state_q == ST_LOAD);
    assign in_ready = busy && (remaining_q != '0);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        ww_d        = ww_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (enc_invalid) begin
                        // Abort: the stream is left where it stopped, nothing more is consumed.
                        error_d = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base_q + ww_q[ADDR_W-1:0];
                        mem_wdata_d = enc_word;
                        ww_d        = ww_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    base_d      = base_addr;
                    remaining_d = count;
                    ww_d        = '0;
                    error_d     = 1'b0;
                    if (count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            remaining_q <= '0;
            ww_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            ww_q        <= ww_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_inst_program_loader.sv
// Randomized bench for inst_program_loader: descriptions are encoded by a table-driven
// reference, and observed writes are compared against an expected write list.
module tb_inst_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, error;
    logic [8:0]  words_written;

    inst_program_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [25:0] imm;
    } desc_t;

    desc_t       dq[$];
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          dc[$];
    int          cyc = 0;
    bit          busy_seen = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [5:0] code_tab [0:14] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010,
                                    6'b101010, 6'b101111, 6'b101000, 6'b010000, 6'b010010,
                                    6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

    // Edge index cyc; outputs observed just after that edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done) dc.push_back(cyc);
        if (busy) busy_seen = 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_enc(input desc_t d);
        logic [5:0] c;
        c = code_tab[int'(d.op)];
        if (d.op <= 4'd9)       return {c, d.rs, d.rt, d.rd, 5'd0, c};
        else if (d.op <= 4'd13) return {c, d.rs, d.rt, d.imm[15:0]};
        else                    return {c, d.imm};
    endfunction

    function automatic desc_t mk(input int op, input int rs, input int rt, input int rd, input int imm);
        desc_t d;
        d.op = 4'(op); d.rs = 5'(rs); d.rt = 5'(rt); d.rd = 5'(rd); d.imm = 26'(imm);
        return d;
    endfunction

    function automatic desc_t rnd_desc(input bit allow_inv);
        desc_t d;
        d.op  = (allow_inv && $urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        d.rs  = 5'($urandom);
        d.rt  = 5'($urandom);
        d.rd  = 5'($urandom);
        d.imm = 26'($urandom);
        return d;
    endfunction

    task automatic clear_mon();
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
        busy_seen = 0;
    endtask

    // gap: 0 none, 1 random idle cycles, 2 one idle cycle after every accept
    task automatic run_load(input logic [7:0] base, input int cnt, input int gap);
        int  exp_n = 0;
        bit  has_inv = 0;
        int  idx = 0;
        int  budget = 300;
        bit  stop = 0;
        bit  acc;
        bit  prev_acc = 0;
        int  start_edge;
        int  acc_edge[$];
        for (int i = 0; i < cnt; i++) begin
            if (dq[i].op == 4'd15) begin has_inv = 1; break; end
            exp_n++;
        end
        clear_mon();
        @(negedge clk);
        start = 1; base_addr = base; count = 9'(cnt);
        start_edge = cyc + 1;
        @(negedge clk);
        start = 0;
        chk("err_clr", error, 0);
        chk("ww_clr", words_written, 0);
        chk("busy_start", busy, cnt != 0);
        while (idx < cnt && !stop && budget > 0) begin
            budget--;
            if ((gap == 1 && $urandom_range(0, 2) == 0) || (gap == 2 && prev_acc)) begin
                in_valid = 0;
            end else begin
                in_valid = 1;
                in_op = dq[idx].op; in_rs = dq[idx].rs; in_rt = dq[idx].rt;
                in_rd = dq[idx].rd; in_imm = dq[idx].imm;
            end
            acc = in_valid && in_ready;
            if (acc) acc_edge.push_back(cyc + 1);
            @(negedge clk);
            prev_acc = acc;
            if (acc) begin
                if (dq[idx].op == 4'd15) stop = 1;
                idx++;
            end
        end
        in_valid = 0;
        if (budget == 0) chk("accept_timeout", 1, 0);
        repeat (3) @(negedge clk);
        chk("n_writes", wa.size(), exp_n);
        for (int i = 0; i < exp_n && i < wa.size(); i++) begin
            chk("wr_addr", wa[i], 8'(base + 8'(i)));
            chk("wr_data", wd[i], ref_enc(dq[i]));
            if (i < acc_edge.size()) chk("wr_latency", wc[i], acc_edge[i]);
        end
        chk("error", error, has_inv);
        chk("n_done", dc.size(), has_inv ? 0 : 1);
        if (!has_inv && dc.size() > 0)
            chk("done_cyc", dc[0], (exp_n == 0) ? start_edge : ((wc.size() > 0) ? wc[wc.size()-1] : -1));
        chk("words_written", words_written, exp_n);
        chk("rdy_off", in_ready, 0);
        chk("busy_off", busy, 0);
        chk("busy_seen", busy_seen, cnt != 0);
        if (wa.size() > 0) begin
            chk("hold_addr", mem_addr, wa[wa.size()-1]);
            chk("hold_data", mem_wdata, wd[wd.size()-1]);
        end
    endtask

    initial begin
        rst = 1; start = 0; base_addr = 0; count = 0; in_valid = 0;
        in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        clear_mon();
        repeat (5) @(negedge clk);
        chk("rst_outs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written}, 0);
        chk("rst_no_we", wa.size(), 0);

        // Directed load with known encodings
        dq.delete();
        dq.push_back(mk(3, 1, 2, 3, 0));
        dq.push_back(mk(10, 1, 4, 0, 26'h0000005));
        dq.push_back(mk(14, 0, 0, 0, 26'h0000040));
        run_load(8'h10, 3, 0);
        if (wd.size() == 3) begin
            chk("add_word", wd[0], 32'h80221820);
            chk("addi_word", wd[1], 32'h20240005);
            chk("j_word", wd[2], 32'h08000040);
        end else chk("known_words", wd.size(), 3);

        run_load(8'h22, 0, 0);

        // Invalid op second of four, then a fresh load clears error
        dq.delete();
        dq.push_back(rnd_desc(0));
        dq.push_back(mk(15, 1, 1, 1, 1));
        dq.push_back(rnd_desc(0));
        dq.push_back(rnd_desc(0));
        run_load(8'h40, 4, 0);
        repeat (2) @(negedge clk);
        chk("err_sticky", error, 1);
        chk("err_rdy", in_ready, 0);
        dq.delete();
        dq.push_back(rnd_desc(0));
        run_load(8'h50, 1, 0);

        // Address wrap with gapped stream
        dq.delete();
        dq.push_back(rnd_desc(0));
        dq.push_back(rnd_desc(0));
        run_load(8'hFF, 2, 2);
        if (wa.size() == 2) chk("wrap_addr", {wa[0], wa[1]}, 16'hFF00);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            int cnt;
            cnt = $urandom_range(1, 8);
            dq.delete();
            for (int i = 0; i < cnt; i++) dq.push_back(rnd_desc(1));
            run_load(8'($urandom), cnt, $urandom_range(0, 1));
        end

        // Reset coincides with the second accept: that word must never appear
        dq.delete();
        for (int i = 0; i < 4; i++) dq.push_back(rnd_desc(0));
        clear_mon();
        @(negedge clk);
        start = 1; base_addr = 8'h80; count = 9'd4;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_op = dq[0].op; in_rs = dq[0].rs; in_rt = dq[0].rt;
        in_rd = dq[0].rd; in_imm = dq[0].imm;
        @(negedge clk);
        in_op = dq[1].op; in_rs = dq[1].rs; in_rt = dq[1].rt; in_rd = dq[1].rd; in_imm = dq[1].imm;
        rst = 1;
        @(negedge clk);
        rst = 0; in_valid = 0;
        chk("midrst_outs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done, error, words_written}, 0);
        repeat (3) @(negedge clk);
        chk("midrst_nwr", wa.size(), 1);
        if (wa.size() > 0) chk("midrst_first", wd[0], ref_enc(dq[0]));
        chk("midrst_idle", {busy, mem_we, words_written}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_program_loader.md
# inst_program_loader

Instruction encoder and loader: the write-side counterpart of the control decoder. Accepts structured instruction descriptions (operation kind plus register/immediate fields) over a valid/ready stream, packs each into a 32-bit instruction word using the same 6-bit control codes the control decoder consumes, and writes the words sequentially into instruction memory from a programmable base address. It sits between the test/boot host and instruction memory, ahead of fetch.

## Interface
- ADDR_W, 8, instruction-memory word-address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load; honoured only when not busy
- base_addr  in  ADDR_W  first word address, sampled on accepted start
- count  in  ADDR_W+1  words to load, sampled on accepted start; 0 legal
- in_valid  in  1  instruction description valid
- in_ready  out  1  loader can accept a description this cycle
- in_op  in  4  operation kind (package enum; 15 = invalid)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  immediate/target; low 16 bits used for I-format
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded instruction word
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse at load completion
- error  out  1  sticky: invalid op received
- words_written  out  ADDR_W+1  words written in current/last load

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset -> IDLE.
- IDLE/DONE/ERR + start: latch base_addr, count; clear error, words_written. count=0 -> DONE with done pulse next cycle, no writes; else -> LOAD.
- LOAD: in_ready = 1 while remaining > 0. Accept on in_valid & in_ready.
- Valid accept: register word; next cycle mem_we=1, mem_addr = base_addr + words_written (mod 2^ADDR_W), words_written++, remaining--.
- Last accept (remaining 1 -> 0): -> DONE; done pulses the same cycle as the final mem_we.
- Invalid op (15) accepted: no write, error=1, -> ERR, in_ready=0 from next cycle. Remaining descriptions are not consumed.
- start while busy: ignored.
- Encoding, op field [31:26] = control code:
  - R-format (AND 100100, OR 100101, NOR 100111, ADD 100000, SUB 100010, SLT 101010, DIV 101111, MULT 101000, MFHI 010000, MFLO 010010): rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0] = same code.
  - I-format (ADDI 001000, LW 100011, SW 101011, BEQ 000100): rs, rt, imm[15:0] = in_imm[15:0].
  - J-format (J 000010): target[25:0] = in_imm[25:0].

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, error 0, words_written 0.
- start at edge N -> busy and in_ready high from cycle N+1.
- Accept at edge N -> mem_we at cycle N+1; one write per cycle sustained at full throughput.
- mem_wdata/mem_addr hold last value when mem_we=0.
- rst mid-load: all outputs return to reset values at that edge; a pending registered word is discarded and never written.
- Address wrap: base_addr=2^ADDR_W-1, count 2 -> writes to 2^ADDR_W-1 then 0.

## Structure
- Shared package mips_pkg: op-kind enum (0..14 in the order listed, 15 invalid), 6-bit control-code constants, field bit-position constants, format enum (R/I/J). The control decoder uses the same code constants.
- One sub-module: inst_encoder, combinational, op kind + fields -> 32-bit word + invalid flag. The loader holds the FSM, counters and output register.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, no mem_we.
- base 0x10, count 3: ADD rs=1 rt=2 rd=3; ADDI rs=1 rt=4 imm=0x0005; J imm=0x0000040 -> writes 0x10:0x80221820, 0x11:0x20240005, 0x12:0x08000040; done at 3rd write; words_written=3.
- count 0 start -> done one cycle later, no mem_we, busy never high.
- Invalid op (15) as 2nd of 4 -> one write only, error=1, in_ready=0 thereafter; new start clears error.
- base 0xFF, count 2, in_valid gapped (1 idle cycle between) -> writes to 0xFF then 0x00, each one cycle after its accept.
- rst asserted cycle after 2nd accept of 4 -> 2nd word never written, outputs at reset values next cycle.
